// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, CHUNK bits per clock.
// A ripple of CHUNK one-bit full-subtractor cells handles the low CHUNK bits of
// the operand shift registers each cycle. The borrow is registered between cycles.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request an operation (accepted only when busy=0)
//   a, b, borrow_in operands, captured on an accepted start
//   busy            high during the N compute cycles
//   done            one-cycle pulse when result outputs update
//   diff            a - b - borrow_in mod 2^WIDTH
//   borrow_out      unsigned borrow out of bit WIDTH-1
//   overflow        signed two's-complement overflow
//   zero            diff == 0
module serial_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0]       chunk_diff;
  logic                   chunk_borrow;
  logic [WIDTH+CHUNK-1:0] res_ext;
  logic [WIDTH-1:0]       res_shifted;

  // Ripple of one-bit full-subtractor cells over the low CHUNK bits.
  always_comb begin
    logic bw;
    bw         = borrow_q;
    chunk_diff = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      chunk_diff[i] = a_q[i] ^ b_q[i] ^ bw;
      bw            = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & bw);
    end
    chunk_borrow = bw;
  end

  // New chunk enters at the top so that after N cycles the result is aligned.
  // The extended vector keeps the slice legal even when CHUNK == WIDTH.
  assign res_ext     = {chunk_diff, res_q};
  assign res_shifted = res_ext[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    zero_d       = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        // DONE accepts start just like IDLE, giving back-to-back operation.
        state_d = StIdle;
        if (start) begin
          state_d  = StRun;
          a_d      = a;
          b_d      = b;
          borrow_d = borrow_in;
          res_d    = '0;
          cnt_d    = '0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
        end
      end
      StRun: begin
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        res_d    = res_shifted;
        borrow_d = chunk_borrow;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d      = StDone;
          cnt_d        = '0;
          diff_d       = res_shifted;
          borrow_out_d = chunk_borrow;
          overflow_d   = (a_msb_q != b_msb_q) && (res_shifted[WIDTH-1] != a_msb_q);
          zero_d       = (res_shifted == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
      zero_q       <= zero_d;
    end
  end

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: one 8-bit instance with CHUNK=1 and one with
// CHUNK=4. A transaction-level model predicts busy/done/results every cycle;
// directed vectors add hand-computed literal expectations.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, start0, bin0, busy0, done0, bo0, ov0, z0;
  logic [7:0] a0, b0, diff0;
  logic       rst1, start1, bin1, busy1, done1, bo1, ov1, z1;
  logic [7:0] a1, b1, diff1;

  serial_subtractor #(.WIDTH(8), .CHUNK(1)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .a(a0), .b(b0), .borrow_in(bin0),
    .busy(busy0), .done(done0), .diff(diff0), .borrow_out(bo0), .overflow(ov0), .zero(z0)
  );

  serial_subtractor #(.WIDTH(8), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .overflow(ov1), .zero(z1)
  );

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: an accepted start schedules a result N cycles later.
  bit       m_run[2], m_done[2], m_bo[2], m_ov[2], m_z[2];
  bit       p_bo[2], p_ov[2], p_z[2];
  int       m_left[2];
  bit [7:0] m_diff[2], p_diff[2];

  task automatic model_step(input int k, input logic r, input logic s, input logic [7:0] ia,
                            input logic [7:0] ib, input logic ibin, input int n);
    int rr, rs;
    if (r) begin
      m_run[k] = 0; m_left[k] = 0; m_done[k] = 0;
      m_diff[k] = 0; m_bo[k] = 0; m_ov[k] = 0; m_z[k] = 0;
    end else begin
      m_done[k] = 0;
      if (m_run[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_run[k] = 0; m_done[k] = 1;
          m_diff[k] = p_diff[k]; m_bo[k] = p_bo[k]; m_ov[k] = p_ov[k]; m_z[k] = p_z[k];
        end
      end else if (s) begin
        m_run[k]  = 1;
        m_left[k] = n;
        rr        = int'(ia) - int'(ib) - int'(ibin);
        p_diff[k] = rr[7:0];
        p_bo[k]   = (rr < 0);
        rs        = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
        p_ov[k]   = (rs < -128) || (rs > 127);
        p_z[k]    = (rr[7:0] == 8'h00);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst0, start0, a0, b0, bin0, 8);
    model_step(1, rst1, start1, a1, b1, bin1, 2);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m0_busy", busy0, m_run[0]);
      chk("m0_done", done0, m_done[0]);
      chk("m0_diff", diff0, m_diff[0]);
      chk("m0_bo", bo0, m_bo[0]);
      chk("m0_ov", ov0, m_ov[0]);
      chk("m0_zero", z0, m_z[0]);
      chk("m1_busy", busy1, m_run[1]);
      chk("m1_done", done1, m_done[1]);
      chk("m1_diff", diff1, m_diff[1]);
      chk("m1_bo", bo1, m_bo[1]);
      chk("m1_ov", ov1, m_ov[1]);
      chk("m1_zero", z1, m_z[1]);
    end
  end

  // Raise start with operands; align=1 first moves to just after a rising edge.
  task automatic launch(input int k, input bit align, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ibin);
    if (align) begin
      @(posedge clk);
      #2;
    end
    if (k == 0) begin a0 = ia; b0 = ib; bin0 = ibin; start0 = 1'b1; end
    else begin a1 = ia; b1 = ib; bin1 = ibin; start1 = 1'b1; end
    @(posedge clk);
    #2;
    if (k == 0) start0 = 1'b0;
    else start1 = 1'b0;
  endtask

  // Counts cycles after acceptance until done; returns in the done cycle.
  task automatic wait_done(input int k, input int exp_lat, input string name);
    int  c;
    bit  seen;
    c    = 0;
    seen = 0;
    while (!seen && c < 30) begin
      @(negedge clk);
      #1;
      c++;
      if ((k == 0) ? done0 : done1) seen = 1;
    end
    chk({name, "_latency"}, c, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1; start0 = 0; a0 = 0; b0 = 0; bin0 = 0;
    rst1 = 1; start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
    repeat (2) @(posedge clk);
    #2;
    rst0 = 0; rst1 = 0; cmp_en = 1;
    @(negedge clk);
    #1;
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_diff", diff0, 0);
    chk("reset_zero", z0, 0);

    // 1: basic subtract; operand inputs scrambled during RUN must be ignored
    launch(0, 1, 8'h50, 8'h20, 0);
    a0 = 8'hAA; b0 = 8'h55; bin0 = 1;
    wait_done(0, 9, "t1");
    chk("t1_diff", diff0, 8'h30);
    chk("t1_bo", bo0, 0);
    chk("t1_ov", ov0, 0);
    chk("t1_zero", z0, 0);

    // 2: unsigned borrow
    launch(0, 1, 8'h00, 8'h01, 0);
    wait_done(0, 9, "t2");
    chk("t2_diff", diff0, 8'hFF);
    chk("t2_bo", bo0, 1);
    chk("t2_ov", ov0, 0);

    // 3: signed overflow
    launch(0, 1, 8'h80, 8'h01, 0);
    wait_done(0, 9, "t3");
    chk("t3_diff", diff0, 8'h7F);
    chk("t3_bo", bo0, 0);
    chk("t3_ov", ov0, 1);

    // 4: zero with borrow_in, then back-to-back start in the DONE cycle
    launch(0, 1, 8'h05, 8'h04, 1);
    wait_done(0, 9, "t4a");
    chk("t4a_diff", diff0, 8'h00);
    chk("t4a_zero", z0, 1);
    chk("t4a_bo", bo0, 0);
    launch(0, 0, 8'h10, 8'h01, 0);
    wait_done(0, 9, "t4b");
    chk("t4b_diff", diff0, 8'h0F);
    chk("t4b_zero", z0, 0);

    // 5: ignored start mid-RUN, then reset abort
    launch(0, 1, 8'h33, 8'h11, 0);   // accepted at edge ending T; now in T+1
    @(posedge clk); #2;              // T+2
    @(posedge clk); #2;              // T+3
    a0 = 8'hFF; b0 = 8'hFE; start0 = 1;
    @(posedge clk); #2;              // T+4
    start0 = 0;
    @(posedge clk); #2;              // T+5
    rst0 = 1;
    @(posedge clk); #2;              // T+6
    rst0 = 0;
    @(negedge clk); #1;
    chk("t5_busy", busy0, 0);
    chk("t5_done", done0, 0);
    chk("t5_diff", diff0, 0);
    repeat (10) @(posedge clk);
    #2;
    chk("t5_idle_busy", busy0, 0);
    launch(0, 0, 8'h50, 8'h20, 0);
    wait_done(0, 9, "t5b");
    chk("t5b_diff", diff0, 8'h30);

    // rst and start together: reset wins
    @(posedge clk); #2;
    rst0 = 1; start0 = 1; a0 = 8'h12; b0 = 8'h34;
    @(posedge clk); #2;
    rst0 = 0; start0 = 0;
    @(negedge clk); #1;
    chk("rst_start_busy", busy0, 0);
    chk("rst_start_diff", diff0, 0);

    // 6: CHUNK=4 instance
    launch(1, 1, 8'h3C, 8'hC3, 0);
    wait_done(1, 3, "t6");
    chk("t6_diff", diff1, 8'h79);
    chk("t6_bo", bo1, 1);
    chk("t6_ov", ov1, 0);
    chk("t6_zero", z1, 0);

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
